// File: rtl/picorv32_mem_responder.sv
// PicoRV32 native memory bus to single-port SRAM responder.
// Serves one request at a time; out-of-range addresses return ERR_DATA with bus_err.
module picorv32_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned ADDR_WORDS   = 512,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF,
    localparam int unsigned ADDR_BITS   = $clog2(ADDR_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    output logic                 bus_err,
    output logic [31:0]          err_addr,
    output logic                 sram_csb,
    output logic                 sram_web,
    output logic [3:0]           sram_wmask,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [31:0]          sram_din,
    input  logic [31:0]          sram_dout
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StErr} state_e;

    localparam logic [32:0] SPAN = 33'(ADDR_WORDS) << 2;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  cnt_q;
    logic [31:0] rdata_q;
    logic [31:0] err_addr_q;

    logic [32:0] req_off;
    logic        in_range;
    logic [31:0] word_off;
    logic        is_read;
    logic        unused_bits;

    // 33-bit offset so a window reaching the top of the address space cannot wrap
    assign req_off  = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
    assign in_range = (mem_addr >= BASE_ADDR) && (req_off < SPAN);
    assign word_off = addr_q - BASE_ADDR;
    assign is_read  = (wstrb_q == 4'b0000);
    assign err_addr = err_addr_q;

    assign unused_bits = ^{mem_instr, word_off};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && mem_valid) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            if (state_q == StIssue && is_read) begin
                cnt_q <= 2'(READ_LATENCY);
            end
            if (state_q == StWait) begin
                cnt_q <= cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    rdata_q <= sram_dout;
                end
            end
            if (state_q == StErr) begin
                err_addr_q <= addr_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = wstrb_q;
        sram_addr  = word_off[ADDR_BITS+1:2];
        sram_din   = wdata_q;
        mem_ready  = 1'b0;
        bus_err    = 1'b0;
        mem_rdata  = '0;
        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    state_d = in_range ? StIssue : StErr;
                end
            end
            StIssue: begin
                sram_csb = 1'b0;
                sram_web = is_read;
                state_d  = is_read ? StWait : StResp;
            end
            StWait: begin
                if (cnt_q == 2'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                mem_ready = 1'b1;
                mem_rdata = is_read ? rdata_q : 32'h0;
                state_d   = StIdle;
            end
            StErr: begin
                mem_ready = 1'b1;
                bus_err   = 1'b1;
                mem_rdata = ERR_DATA;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
